writeback_stage: RTL and testbench

- Final pipeline stage, directly downstream of the memory stage; consumes its registered output fields.
- Commits results to the 32x32 integer register file and serves the two decode read ports.
- Resolves conditional branches from the flags/cond fields and issues a one-cycle PC redirect.
- Squashes younger in-flight instructions for a fixed number of cycles after a redirect, and maintains the cycle and instret counters.

---
 rtl/writeback_stage.sv | 166 ++++++++++++++++
 tb/tb_writeback_stage.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Final pipeline stage: register-file commit, branch resolution with fetch redirect,
// post-redirect squash window, commit trace and cycle/instret counters.
//
// state | meaning
// RUN   | instructions from the memory stage are accepted and committed
// FLUSH | younger instructions are discarded until the flush counter expires
module writeback_stage #(
  parameter int unsigned FLUSH_DEPTH = 3,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic        in_wback,
  input  logic [4:0]  in_wreg,
  input  logic [31:0] in_wdata,
  input  logic        in_branch,
  input  logic [3:0]  in_flags,
  input  logic [2:0]  in_cond,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        squashing,
  output logic        commit_valid,
  output logic [31:0] commit_pc,
  output logic [4:0]  commit_reg,
  output logic [31:0] commit_data,
  output logic [63:0] cycle_count,
  output logic [63:0] instret
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_DEPTH);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  flush_cnt, flush_cnt_nxt;
  logic [31:0] regs [32];

  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_true;
  logic accept;
  logic taken;
  logic do_write;

  assign {flag_n, flag_z, flag_c, flag_v} = in_flags;

  always_comb begin
    cond_true = 1'b0;
    case (in_cond)
      3'd0:    cond_true = flag_z;
      3'd1:    cond_true = ~flag_z;
      3'd2:    cond_true = flag_n ^ flag_v;
      3'd3:    cond_true = ~(flag_n ^ flag_v);
      3'd4:    cond_true = ~flag_c;
      3'd5:    cond_true = flag_c;
      3'd6:    cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  assign accept   = in_valid & (state == RUN);
  assign taken    = accept & in_branch & cond_true;
  assign do_write = accept & in_wback & (in_wreg != 5'd0);

  // Write-first bypass so decode sees a result in the cycle it commits.
  always_comb begin
    rs1_data = 32'd0;
    if (rs1_addr != 5'd0) begin
      if (do_write && (in_wreg == rs1_addr)) rs1_data = in_wdata;
      else                                   rs1_data = regs[rs1_addr];
    end
  end

  always_comb begin
    rs2_data = 32'd0;
    if (rs2_addr != 5'd0) begin
      if (do_write && (in_wreg == rs2_addr)) rs2_data = in_wdata;
      else                                   rs2_data = regs[rs2_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      flush_cnt <= 4'd0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // The flush counter runs unconditionally; branches seen in FLUSH never reload it.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    case (state)
      RUN: begin
        if (taken) begin
          state_nxt     = FLUSH;
          flush_cnt_nxt = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        flush_cnt_nxt = flush_cnt - 4'd1;
        if (flush_cnt == 4'd1) state_nxt = RUN;
      end
      default: begin
        state_nxt     = RUN;
        flush_cnt_nxt = 4'd0;
      end
    endcase
  end

  assign squashing = (state == FLUSH);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (do_write) begin
      regs[in_wreg] <= in_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= RESET_PC;
    end else begin
      redirect_valid <= taken;
      if (taken) redirect_pc <= in_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      commit_valid <= 1'b0;
      commit_pc    <= 32'd0;
      commit_reg   <= 5'd0;
      commit_data  <= 32'd0;
    end else begin
      commit_valid <= accept;
      commit_pc    <= accept   ? in_pc    : 32'd0;
      commit_reg   <= do_write ? in_wreg  : 5'd0;
      commit_data  <= do_write ? in_wdata : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count <= 64'd0;
      instret     <= 64'd0;
    end else begin
      cycle_count <= cycle_count + 64'd1;
      if (accept) instret <= instret + 64'd1;
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against an architectural model.
module tb_writeback_stage;

  localparam int unsigned FLUSH_DEPTH = 3;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_pc;
  logic        in_wback;
  logic [4:0]  in_wreg;
  logic [31:0] in_wdata;
  logic        in_branch;
  logic [3:0]  in_flags;
  logic [2:0]  in_cond;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        squashing;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [4:0]  commit_reg;
  logic [31:0] commit_data;
  logic [63:0] cycle_count;
  logic [63:0] instret;

  writeback_stage #(.FLUSH_DEPTH(FLUSH_DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_pc(in_pc), .in_wback(in_wback), .in_wreg(in_wreg),
    .in_wdata(in_wdata), .in_branch(in_branch), .in_flags(in_flags), .in_cond(in_cond),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .squashing(squashing),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_reg(commit_reg),
    .commit_data(commit_data), .cycle_count(cycle_count), .instret(instret)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit armed = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural model: register array, remaining squash cycles, expected outputs.
  logic [31:0] m_regs [32];
  int          m_flush_left;
  logic        m_redirect_valid;
  logic [31:0] m_redirect_pc;
  logic        m_commit_valid;
  logic [31:0] m_commit_pc;
  logic [4:0]  m_commit_reg;
  logic [31:0] m_commit_data;
  logic [63:0] m_cycle;
  logic [63:0] m_instret;

  function automatic bit m_taken_cond(input logic [3:0] f, input logic [2:0] c);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      3'd0: return z;
      3'd1: return !z;
      3'd2: return n != v;
      3'd3: return n == v;
      3'd4: return !cy;
      3'd5: return cy;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (in_valid && m_flush_left == 0 && in_wback && in_wreg == a) return in_wdata;
    return m_regs[a];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_flush_left     = 0;
      m_redirect_valid = 1'b0;
      m_redirect_pc    = RESET_PC;
      m_commit_valid   = 1'b0;
      m_commit_pc      = 32'd0;
      m_commit_reg     = 5'd0;
      m_commit_data    = 32'd0;
      m_cycle          = 64'd0;
      m_instret        = 64'd0;
    end else begin
      bit acc;
      acc = in_valid && (m_flush_left == 0);
      m_cycle++;
      if (m_flush_left > 0) m_flush_left--;
      m_redirect_valid = 1'b0;
      m_commit_valid   = acc;
      m_commit_reg     = 5'd0;
      m_commit_data    = 32'd0;
      if (acc) begin
        m_instret++;
        m_commit_pc = in_pc;
        if (in_wback && in_wreg != 5'd0) begin
          m_regs[in_wreg] = in_wdata;
          m_commit_reg    = in_wreg;
          m_commit_data   = in_wdata;
        end
        if (in_branch && m_taken_cond(in_flags, in_cond)) begin
          m_redirect_valid = 1'b1;
          m_redirect_pc    = in_wdata;
          m_flush_left     = FLUSH_DEPTH;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      if (!rst) begin
        check("rs1_data", rs1_data, m_read(rs1_addr));
        check("rs2_data", rs2_data, m_read(rs2_addr));
      end
      check("redirect_valid", redirect_valid, m_redirect_valid);
      check("redirect_pc", redirect_pc, m_redirect_pc);
      check("squashing", squashing, m_flush_left > 0);
      check("commit_valid", commit_valid, m_commit_valid);
      if (m_commit_valid) begin
        check("commit_pc", commit_pc, m_commit_pc);
        check("commit_reg", commit_reg, m_commit_reg);
        check("commit_data", commit_data, m_commit_data);
      end
      check("cycle_count", cycle_count, m_cycle);
      check("instret", instret, m_instret);
    end
  end

  logic [31:0] pc_ctr = 32'h1000;

  task automatic drive(input logic v, input logic wb, input logic [4:0] wr,
                       input logic [31:0] wd, input logic br, input logic [3:0] fl,
                       input logic [2:0] cd);
    in_valid  = v;
    in_wback  = wb;
    in_wreg   = wr;
    in_wdata  = wd;
    in_branch = br;
    in_flags  = fl;
    in_cond   = cd;
    in_pc     = pc_ctr;
    pc_ctr    = pc_ctr + 32'd4;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 4'd0, 3'd7);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    armed = 1'b1;

    // Reset state
    rs1_addr = 5'd5;
    rs2_addr = 5'd31;
    @(negedge clk);
    check("lit_reset_rs1", rs1_data, 32'd0);
    check("lit_reset_rs2", rs2_data, 32'd0);
    check("lit_reset_redirect_valid", redirect_valid, 1'b0);
    check("lit_reset_redirect_pc", redirect_pc, RESET_PC);
    check("lit_reset_cycle", cycle_count, 64'd0);
    check("lit_reset_instret", instret, 64'd0);
    next_cycle();

    // Write with same-cycle bypass, then visible from the array
    drive(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 4'd0, 3'd7);
    rs1_addr = 5'd5;
    @(negedge clk);
    check("lit_bypass_same_cycle", rs1_data, 32'hDEAD_BEEF);
    next_cycle();
    idle();
    @(negedge clk);
    check("lit_array_next_cycle", rs1_data, 32'hDEAD_BEEF);
    check("lit_commit_reg5", commit_reg, 5'd5);
    check("lit_instret_1", instret, 64'd1);
    next_cycle();

    // Write to x0 is dropped but still retires
    drive(1'b1, 1'b1, 5'd0, 32'd7, 1'b0, 4'd0, 3'd7);
    rs1_addr = 5'd0;
    @(negedge clk);
    check("lit_x0_read", rs1_data, 32'd0);
    next_cycle();
    idle();
    @(negedge clk);
    check("lit_x0_commit_valid", commit_valid, 1'b1);
    check("lit_x0_commit_reg", commit_reg, 5'd0);
    check("lit_x0_instret", instret, 64'd2);
    next_cycle();

    // Taken BEQ, then writes offered during the squash window
    drive(1'b1, 1'b0, 5'd0, 32'h100, 1'b1, 4'b0100, 3'd0);
    next_cycle();
    rs2_addr = 5'd7;
    for (int i = 0; i < FLUSH_DEPTH; i++) begin
      drive(1'b1, 1'b1, 5'd7, 32'h55, 1'b1, 4'b0100, 3'd6);
      @(negedge clk);
      check("lit_flush_squashing", squashing, 1'b1);
      check("lit_flush_redirect_valid", redirect_valid, i == 0);
      check("lit_flush_rs2_x7", rs2_data, 32'd0);
      if (i == 0) check("lit_redirect_pc", redirect_pc, 32'h100);
      next_cycle();
    end
    drive(1'b1, 1'b1, 5'd8, 32'h77, 1'b0, 4'd0, 3'd7);
    rs1_addr = 5'd8;
    @(negedge clk);
    check("lit_after_flush_squashing", squashing, 1'b0);
    check("lit_after_flush_instret", instret, 64'd3);
    check("lit_after_flush_bypass", rs1_data, 32'h77);
    next_cycle();

    // Not-taken BEQ
    drive(1'b1, 1'b0, 5'd0, 32'h300, 1'b1, 4'b0000, 3'd0);
    next_cycle();
    idle();
    @(negedge clk);
    check("lit_nt_redirect_valid", redirect_valid, 1'b0);
    check("lit_nt_commit_valid", commit_valid, 1'b1);
    check("lit_nt_squashing", squashing, 1'b0);
    check("lit_nt_instret", instret, 64'd5);
    next_cycle();

    // JAL with link, then reset in the middle of the flush
    drive(1'b1, 1'b1, 5'd1, 32'h200, 1'b1, 4'd0, 3'd6);
    next_cycle();
    idle();
    rs1_addr = 5'd1;
    @(negedge clk);
    check("lit_jal_link", rs1_data, 32'h200);
    check("lit_jal_redirect_valid", redirect_valid, 1'b1);
    check("lit_jal_redirect_pc", redirect_pc, 32'h200);
    check("lit_jal_squashing", squashing, 1'b1);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("lit_rst_squashing", squashing, 1'b0);
    check("lit_rst_x1", rs1_data, 32'd0);
    check("lit_rst_redirect_pc", redirect_pc, RESET_PC);
    check("lit_rst_instret", instret, 64'd0);
    next_cycle();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] wr;
      wr = 5'($urandom_range(0, 31));
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, wr, $urandom(),
            $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
      rs1_addr = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      rs2_addr = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      rst = ($urandom_range(0, 199) == 0);
      next_cycle();
    end
    rst = 1'b0;
    idle();
    next_cycle();
    @(negedge clk);
    armed = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
